// File: rtl/vdp18_pkg.sv
// vdp18_pkg: shared VDP18 types (VRAM slot kinds from the scheduler, CPU port state).
// Fixed geometry: 14-bit VRAM address, 8-bit data.
package vdp18_pkg;

  localparam int unsigned VRAM_AW = 14;
  localparam int unsigned VRAM_DW = 8;

  typedef enum logic [3:0] {
    AC_NONE = 4'd0,
    AC_PNT  = 4'd1,
    AC_PGT  = 4'd2,
    AC_PCT  = 4'd3,
    AC_STST = 4'd4,
    AC_SATY = 4'd5,
    AC_SATX = 4'd6,
    AC_SATN = 4'd7,
    AC_SATC = 4'd8,
    AC_SPT1 = 4'd9,
    AC_SPT2 = 4'd10,
    AC_CPU  = 4'd11
  } access_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    WR_PEND = 2'd2
  } cpu_port_state_t;

endpackage

// File: rtl/vdp18_cpu_vram_port.sv
// CPU data/control port: holds one VRAM access until an AC_CPU slot grant; a newer access replaces it, no backpressure.
// Register strobe appears one clock after the second control byte. Option: VDP18_WR_UPDATES_RDBUF_EN.
module vdp18_cpu_vram_port
  import vdp18_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               clk_en_i,
  input  logic               rd_i,
  input  logic               wr_i,
  input  logic               mode_i,
  input  logic [0:VRAM_DW-1] cd_i,
  output logic [0:VRAM_DW-1] cd_o,
  input  access_t            access_type_i,
  input  logic [0:VRAM_DW-1] vram_d_i,
  output logic [0:VRAM_AW-1] cpu_vram_a_o,
  output logic [0:VRAM_DW-1] vram_d_o,
  output logic               vram_we_o,
  output logic               req_o,
  output logic               reg_wr_o,
  output logic [0:2]         reg_addr_o,
  output logic [0:VRAM_DW-1] reg_data_o
);

  cpu_port_state_t    r_state;
  cpu_port_state_t    w_state_nxt;
  logic [0:VRAM_AW-1] r_addr;
  logic [0:VRAM_DW-1] r_rdbuf;
  logic [0:VRAM_DW-1] r_wrbuf;
  logic [0:VRAM_DW-1] r_tmp;
  logic               r_flag;
  logic               r_reg_wr;
  logic [0:2]         r_reg_addr;
  logic [0:VRAM_DW-1] r_reg_data;

  logic w_data_wr;
  logic w_data_rd;
  logic w_ctrl_wr;
  logic w_ctrl_rd;
  logic w_grant;
  logic w_addr_ld;
  logic w_reg_ld;

  // A simultaneous rd_i/wr_i is a write.
  assign w_data_wr = wr_i && !mode_i;
  assign w_data_rd = rd_i && !wr_i && !mode_i;
  assign w_ctrl_wr = wr_i && mode_i;
  assign w_ctrl_rd = rd_i && !wr_i && mode_i;
  assign w_grant   = clk_en_i && (access_type_i == AC_CPU) && (r_state != IDLE);
  assign w_addr_ld = w_ctrl_wr && r_flag && !cd_i[0];
  assign w_reg_ld  = w_ctrl_wr && r_flag && cd_i[0];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The grant retires the pending access first; any new access becomes pending after it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_grant) begin
      w_state_nxt = IDLE;
    end
    if (w_data_wr) begin
      w_state_nxt = WR_PEND;
    end else if (w_data_rd) begin
      w_state_nxt = RD_PEND;
    end else if (w_addr_ld) begin
      w_state_nxt = cd_i[1] ? IDLE : RD_PEND;
    end
  end

  always_comb begin
    req_o     = (r_state != IDLE);
    vram_we_o = (r_state == WR_PEND) && (access_type_i == AC_CPU);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_addr     <= '0;
      r_rdbuf    <= '0;
      r_wrbuf    <= '0;
      r_tmp      <= '0;
      r_flag     <= 1'b0;
      r_reg_wr   <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
    end else begin
      r_reg_wr <= w_reg_ld;
      if (w_reg_ld) begin
        r_reg_addr <= cd_i[5:7];
        r_reg_data <= r_tmp;
      end
      // A fresh address load overrides the grant's post-increment.
      if (w_addr_ld) begin
        r_addr <= {cd_i[2:7], r_tmp};
      end else if (w_grant) begin
        r_addr <= r_addr + 14'd1;
      end
      if (w_grant && (r_state == RD_PEND)) begin
        r_rdbuf <= vram_d_i;
      end
`ifdef VDP18_WR_UPDATES_RDBUF_EN
      if (w_data_wr) begin
        r_rdbuf <= cd_i;
      end
`endif
      if (w_data_wr) begin
        r_wrbuf <= cd_i;
      end
      if (w_ctrl_wr && !r_flag) begin
        r_tmp <= cd_i;
      end
      if (w_ctrl_wr) begin
        r_flag <= !r_flag;
      end else if (w_data_wr || w_data_rd || w_ctrl_rd) begin
        r_flag <= 1'b0;
      end
    end
  end

  assign cd_o         = r_rdbuf;
  assign cpu_vram_a_o = r_addr;
  assign vram_d_o     = r_wrbuf;
  assign reg_wr_o     = r_reg_wr;
  assign reg_addr_o   = r_reg_addr;
  assign reg_data_o   = r_reg_data;

endmodule
